// File: rtl/soc_system_endstop_in.sv
// Avalon-MM PIO-style input port for endstop switches: synchronise, debounce,
// capture edges on the debounced level and raise a maskable level interrupt.
module soc_system_endstop_in #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEB_RST   = 1000,
  parameter int unsigned EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DEBLEN  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] deblen_q, deblen_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;

  logic             wr_c;
  logic [WIDTH-1:0] edge_set_c;
  logic [WIDTH-1:0] cap_clr_c;
  logic             unused_wdata;

  assign wr_c = chipselect & ~write_n;

  // Only the low bits of writedata land in registers; the rest is don't-care.
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce: level moves after DEBLEN+1 consecutive mismatch cycles.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= deblen_q) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q  <= '0;
      prev_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q  <= deb_d;
      prev_q <= deb_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edge detect on the debounced level.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_set_c = deb_q & ~prev_q;
      1:       edge_set_c = ~deb_q & prev_q;
      default: edge_set_c = deb_q ^ prev_q;
    endcase
  end

  // Register write decode; a capture set beats a same-cycle W1C clear.
  always_comb begin
    deblen_d  = deblen_q;
    irqmask_d = irqmask_q;
    cap_clr_c = '0;
    if (wr_c && (address == ADDR_DEBLEN)) begin
      deblen_d = writedata[CNT_W-1:0];
    end
    if (wr_c && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_c && (address == ADDR_EDGECAP)) begin
      cap_clr_c = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~cap_clr_c) | edge_set_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deblen_q  <= CNT_W'(DEB_RST);
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      deblen_q  <= deblen_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // Zero-wait-state read mux; independent of chipselect, no side effects.
  always_comb begin
    case (address)
      ADDR_DATA:    readdata = DATA_W'(deb_q);
      ADDR_DEBLEN:  readdata = DATA_W'(deblen_q);
      ADDR_IRQMASK: readdata = DATA_W'(irqmask_q);
      ADDR_EDGECAP: readdata = DATA_W'(edgecap_q);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_endstop_in.sv
// Bench for soc_system_endstop_in: directed scenarios plus randomized traffic,
// all checked against a run-length based behavioural model of the port.
module tb_soc_system_endstop_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Model state: register image, debounced level, mismatch run lengths.
  int         m_deblen;
  logic [2:0] m_deb, m_mask, m_cap, m_pend;
  int         m_run [3];
  logic [2:0] m_hist [$];

  soc_system_endstop_in #(
    .WIDTH(3), .CNT_W(16), .DEB_RST(1000), .EDGE_TYPE(0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  function automatic void model_reset();
    m_deblen = 1000;
    m_deb    = '0;
    m_mask   = '0;
    m_cap    = '0;
    m_pend   = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_hist = {3'b000, 3'b000};
  endfunction

  // One clock edge of behaviour, using the bus/pin values present at the edge.
  function automatic void model_step();
    logic [2:0] sync_v, old_deb, clr;
    logic       wr;
    sync_v = m_hist.pop_front();
    m_hist.push_back(in_port);
    old_deb = m_deb;
    for (int i = 0; i < 3; i++) begin
      if (sync_v[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] > m_deblen) begin
          m_deb[i] = sync_v[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[2:0] : 3'b000;
    m_cap  = (m_cap & ~clr) | m_pend;
    m_pend = m_deb & ~old_deb;
    if (wr && address == 2'd1) m_deblen = int'(writedata[15:0]);
    if (wr && address == 2'd2) m_mask = writedata[2:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (reset_n) model_step();
    else         model_reset();
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    checks++;
    assert (readdata === exp)
      else begin
        errors++;
        $error("FAIL %s addr=%0d: readdata=0x%08h expected 0x%08h", tag, a, readdata, exp);
      end
  endtask

  task automatic irq_chk(input logic exp, input string tag);
    checks++;
    assert (irq === exp)
      else begin
        errors++;
        $error("FAIL %s: irq=%b expected %b", tag, irq, exp);
      end
  endtask

  task automatic chk_all(input string tag);
    rd_chk(2'd0, 32'(m_deb), tag);
    rd_chk(2'd1, 32'(m_deblen), tag);
    rd_chk(2'd2, 32'(m_mask), tag);
    rd_chk(2'd3, 32'(m_cap), tag);
    irq_chk(|(m_cap & m_mask), tag);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = '0;
    model_reset();

    // Reset with random bus activity
    repeat (5) begin
      chipselect = 1'($urandom);
      write_n    = 1'($urandom);
      address    = 2'($urandom);
      writedata  = $urandom;
      cyc();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    #2 reset_n = 1'b1;
    rd_chk(2'd0, 32'h0, "rst_data");
    rd_chk(2'd1, 32'd1000, "rst_deblen");
    rd_chk(2'd2, 32'h0, "rst_mask");
    rd_chk(2'd3, 32'h0, "rst_cap");
    irq_chk(1'b0, "rst_irq");
    cyc();
    chk_all("post_rst");

    // Debounce timing with DEBLEN=4: DATA at 7 cycles, not 6
    do_write(2'd1, 32'd4);
    in_port[0] = 1'b1;
    repeat (6) cyc();
    rd_chk(2'd0, 32'h0, "deb_at6");
    chk_all("deb_at6_model");
    cyc();
    rd_chk(2'd0, 32'h1, "deb_at7");
    cyc();
    rd_chk(2'd3, 32'h1, "deb_cap");
    irq_chk(1'b0, "deb_cap_masked");
    do_write(2'd3, 32'h7);
    chk_all("deb_clr");

    // Glitch rejection: 4-cycle pulse on bit1
    in_port[1] = 1'b1;
    repeat (4) begin cyc(); chk_all("glitch_hi"); end
    in_port[1] = 1'b0;
    repeat (10) begin cyc(); chk_all("glitch_lo"); end
    rd_chk(2'd0, 32'h1, "glitch_data");
    rd_chk(2'd3, 32'h0, "glitch_cap");

    // Edge capture and irq on bit2
    do_write(2'd2, 32'h4);
    in_port[2] = 1'b1;
    repeat (8) cyc();
    rd_chk(2'd3, 32'h4, "edge_cap");
    irq_chk(1'b1, "edge_irq");
    chk_all("edge_model");
    do_write(2'd3, 32'h4);
    rd_chk(2'd3, 32'h0, "w1c_cap");
    irq_chk(1'b0, "w1c_irq");
    in_port[2] = 1'b0;
    repeat (10) begin cyc(); chk_all("fall"); end
    rd_chk(2'd3, 32'h0, "fall_no_cap");

    // Set/clear collision on bit0
    in_port[0] = 1'b0;
    repeat (10) cyc();
    in_port[0] = 1'b1;
    repeat (7) cyc();
    rd_chk(2'd0, 32'h1, "coll_deb");
    rd_chk(2'd3, 32'h0, "coll_precap");
    do_write(2'd3, 32'h1);
    rd_chk(2'd3, 32'h1, "coll_set_wins");
    chk_all("coll_model");

    // Masked capture with DEBLEN=0, then unmask
    do_write(2'd2, 32'h0);
    do_write(2'd1, 32'h0);
    do_write(2'd3, 32'h7);
    in_port[0] = 1'b0;
    repeat (2) cyc();
    rd_chk(2'd0, 32'h1, "d0_fall_at2");
    cyc();
    rd_chk(2'd0, 32'h0, "d0_fall_at3");
    in_port[0] = 1'b1;
    repeat (3) cyc();
    rd_chk(2'd0, 32'h1, "d0_rise_at3");
    cyc();
    rd_chk(2'd3, 32'h1, "d0_cap");
    irq_chk(1'b0, "d0_masked_irq");
    address    = 2'd2;
    writedata  = 32'h1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    #1 irq_chk(1'b0, "unmask_before");
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
    irq_chk(1'b1, "unmask_after");
    chk_all("unmask_model");

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) in_port = 3'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          address    = 2'($urandom);
          writedata  = (address == 2'd1) ? (($urandom & 32'hFFFF_0000) | $urandom_range(0, 6))
                                         : $urandom;
          chipselect = 1'b1;
          write_n    = 1'b0;
        end
        3: begin
          address    = 2'($urandom);
          writedata  = $urandom;
          chipselect = 1'b0;
          write_n    = 1'b0;
        end
        default: begin
          chipselect = 1'($urandom);
          write_n    = 1'b1;
          writedata  = $urandom;
        end
      endcase
      cyc();
      chipselect = 1'b0;
      write_n    = 1'b1;
      chk_all("rand");
    end

    // Asynchronous reset drops irq immediately
    do_write(2'd1, 32'h0);
    do_write(2'd2, 32'h7);
    in_port = 3'b000;
    repeat (5) cyc();
    do_write(2'd3, 32'h7);
    in_port = 3'b111;
    repeat (5) cyc();
    irq_chk(1'b1, "pre_async_irq");
    #3 reset_n = 1'b0;
    #1 irq_chk(1'b0, "async_rst_irq");
    model_reset();
    rd_chk(2'd1, 32'd1000, "async_rst_deblen");
    rd_chk(2'd3, 32'h0, "async_rst_cap");
    repeat (2) cyc();
    #2 reset_n = 1'b1;
    chk_all("final_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
